// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out frame serializer with first/last markers and gapless back-to-back frames.
// Optional trailing even-parity symbol when the macro PISO_PARITY_EN is defined.
module piso_frame_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             s_out,
   output logic             s_valid,
   output logic             s_first,
   output logic             s_last
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
   typedef enum logic {IDLE, SHIFT} state_e;
`endif

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              s_out_q, s_out_d;
   logic              s_valid_q, s_valid_d;
   logic              s_first_q, s_first_d;
   logic              s_last_q, s_last_d;
   logic              accept;
   logic              frame_done;
`ifdef PISO_PARITY_EN
   logic              parity_q, parity_d;
`endif

   // Ready while idle, or while the final symbol of the current frame is on the wire.
   assign load_ready = (state_q == IDLE) | s_last_q;
   assign accept     = load_valid & load_ready;

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      s_out_d    = s_out_q;
      s_valid_d  = s_valid_q;
      s_first_d  = s_first_q;
      s_last_d   = s_last_q;
      frame_done = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         SHIFT: begin
            if (cnt_q == LAST_CNT) begin
`ifdef PISO_PARITY_EN
               state_d   = PARITY;
               s_out_d   = parity_q;
               s_first_d = 1'b0;
               s_last_d  = 1'b1;
               cnt_d     = cnt_q + CW'(1);
`else
               frame_done = 1'b1;
`endif
            end else begin
               if (MSB_FIRST) begin
                  s_out_d = shreg_q[WIDTH-1];
                  shreg_d = shreg_q << 1;
               end else begin
                  s_out_d = shreg_q[0];
                  shreg_d = shreg_q >> 1;
               end
               cnt_d     = cnt_q + CW'(1);
               s_first_d = 1'b0;
`ifdef PISO_PARITY_EN
               s_last_d  = 1'b0;
`else
               s_last_d  = ((cnt_q + CW'(1)) == LAST_CNT);
`endif
            end
         end
         default: frame_done = 1'b1;
      endcase

      // Idle and the end of a frame share one decision: start a new frame or go quiet.
      if (frame_done) begin
         if (accept) begin
            state_d   = SHIFT;
            shreg_d   = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
            s_out_d   = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            s_valid_d = 1'b1;
            s_first_d = 1'b1;
            s_last_d  = 1'b0;
            cnt_d     = '0;
`ifdef PISO_PARITY_EN
            parity_d  = ^load_data;
`endif
         end else begin
            state_d   = IDLE;
            shreg_d   = '0;
            s_out_d   = 1'b0;
            s_valid_d = 1'b0;
            s_first_d = 1'b0;
            s_last_d  = 1'b0;
            cnt_d     = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         s_out_q   <= 1'b0;
         s_valid_q <= 1'b0;
         s_first_q <= 1'b0;
         s_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         s_out_q   <= s_out_d;
         s_valid_q <= s_valid_d;
         s_first_q <= s_first_d;
         s_last_q  <= s_last_d;
`ifdef PISO_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign s_out   = s_out_q;
   assign s_valid = s_valid_q;
   assign s_first = s_first_q;
   assign s_last  = s_last_q;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Bench for piso_frame_serializer: MSB-first and LSB-first instances share one stimulus stream
// and are compared each cycle against a symbol-queue reference model plus a word scoreboard.
module tb_piso_frame_serializer;

   localparam int W = 4;

   logic         clk;
   logic         clear;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         ready_msb, out_msb, valid_msb, first_msb, last_msb;
   logic         ready_lsb, out_lsb, valid_lsb, first_lsb, last_lsb;

   piso_frame_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .clear(clear), .load_valid(load_valid), .load_ready(ready_msb),
      .load_data(load_data), .s_out(out_msb), .s_valid(valid_msb),
      .s_first(first_msb), .s_last(last_msb)
   );

   piso_frame_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .clear(clear), .load_valid(load_valid), .load_ready(ready_lsb),
      .load_data(load_data), .s_out(out_lsb), .s_valid(valid_lsb),
      .s_first(first_lsb), .s_last(last_lsb)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: the symbols still to be sent for the current frame, per bit order.
   bit           m_init = 1'b0;
   bit           m_v = 1'b0, m_f = 1'b0, m_l = 1'b0;
   bit           m_o_msb = 1'b0, m_o_lsb = 1'b0;
   bit           mq_msb[$];
   bit           mq_lsb[$];
   bit           last_acc = 1'b0;

   // Scoreboard: words accepted, and words reassembled from the serial stream.
   logic [W-1:0] exp_msb[$];
   logic [W-1:0] exp_lsb[$];
   logic [W-1:0] w_msb = '0, w_lsb = '0;
   int           n_msb = 0, n_lsb = 0;

   task automatic collect(input bit msb, input logic so, input logic sv, input logic sf,
                          inout logic [W-1:0] w, inout int n);
      if (sv === 1'b1) begin
         if (sf === 1'b1) begin
            n = 0;
            w = '0;
         end
         if (n < W) begin
            if (msb) w = {w[W-2:0], so};
            else     w = {so, w[W-1:1]};
            n++;
         end
      end
   endtask

   // One clock of stimulus: drive at negedge, predict at posedge, compare 1 time unit later.
   task automatic cyc(input bit v, input logic [W-1:0] d, input bit c);
      bit rdy;
      bit acc;
      logic [W-1:0] e;
      load_valid = v;
      load_data  = d;
      clear      = c;
      #1;
      rdy = !m_v || (mq_msb.size() == 0);
      if (m_init) begin
         chk("ready_msb", ready_msb, rdy);
         chk("ready_lsb", ready_lsb, rdy);
      end
      @(posedge clk);
      if (c) begin
         m_v = 0; m_f = 0; m_o_msb = 0; m_o_lsb = 0;
         mq_msb.delete(); mq_lsb.delete();
         exp_msb.delete(); exp_lsb.delete();
         n_msb = 0; n_lsb = 0;
         m_init = 1; last_acc = 0;
      end else begin
         acc = v && rdy;
         last_acc = acc;
         if (acc) begin
            for (int i = W - 1; i >= 0; i--) mq_msb.push_back(d[i]);
            for (int i = 0; i < W; i++)      mq_lsb.push_back(d[i]);
`ifdef PISO_PARITY_EN
            mq_msb.push_back(^d);
            mq_lsb.push_back(^d);
`endif
            exp_msb.push_back(d);
            exp_lsb.push_back(d);
         end
         if (mq_msb.size() > 0) begin
            m_o_msb = mq_msb.pop_front();
            m_o_lsb = mq_lsb.pop_front();
            m_v = 1;
            m_f = acc;
         end else begin
            m_v = 0; m_f = 0; m_o_msb = 0; m_o_lsb = 0;
         end
      end
      m_l = m_v && (mq_msb.size() == 0);
      #1;
      chk("valid_msb", valid_msb, m_v);
      chk("first_msb", first_msb, m_f);
      chk("last_msb",  last_msb,  m_l);
      chk("out_msb",   out_msb,   m_o_msb);
      chk("valid_lsb", valid_lsb, m_v);
      chk("first_lsb", first_lsb, m_f);
      chk("last_lsb",  last_lsb,  m_l);
      chk("out_lsb",   out_lsb,   m_o_lsb);
      if (!c) begin
         collect(1'b1, out_msb, valid_msb, first_msb, w_msb, n_msb);
         collect(1'b0, out_lsb, valid_lsb, first_lsb, w_lsb, n_lsb);
         if (last_msb === 1'b1) begin
            if (exp_msb.size() > 0) begin
               e = exp_msb.pop_front();
               chk("word_msb", w_msb, e);
            end else chk("word_msb_unexpected", 1, 0);
         end
         if (last_lsb === 1'b1) begin
            if (exp_lsb.size() > 0) begin
               e = exp_lsb.pop_front();
               chk("word_lsb", w_lsb, e);
            end else chk("word_lsb_unexpected", 1, 0);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      bit           v;
      bit           c;
      logic [W-1:0] d;
      clear = 1'b0;
      load_valid = 1'b0;
      load_data = '0;
      @(negedge clk);

      // Reset held two cycles with a word offered: nothing may be accepted.
      cyc(1'b1, 4'b1011, 1'b1);
      cyc(1'b1, 4'b1011, 1'b1);

      // Single frame, then idle.
      cyc(1'b1, 4'b1011, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 4'b0000, 1'b0);

      // Back-to-back: second word held valid until the final-symbol window.
      cyc(1'b1, 4'b1011, 1'b0);
      for (int i = 0; i < W + 1; i++) cyc(1'b1, 4'b0110, 1'b0);
      for (int i = 0; i < 7; i++) cyc(1'b0, 4'b0000, 1'b0);

      // Abort on cycle 2 with a concurrent offer, then a fresh frame.
      cyc(1'b1, 4'b1011, 1'b0);
      cyc(1'b0, 4'b0000, 1'b0);
      cyc(1'b1, 4'b1111, 1'b1);
      cyc(1'b1, 4'b0001, 1'b0);
      for (int i = 0; i < 7; i++) cyc(1'b0, 4'b0000, 1'b0);

      // Random traffic; a word stays stable while offered and not yet accepted.
      v = 0;
      d = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!(v && !last_acc)) begin
            v = ($urandom_range(0, 3) != 0);
            d = W'($urandom);
         end
         c = ($urandom_range(0, 99) == 0);
         last_acc = 0;
         cyc(v, d, c);
         if (c) v = 0;
      end
      for (int i = 0; i < 8; i++) cyc(1'b0, 4'b0000, 1'b0);
      chk("drain_msb", exp_msb.size(), 0);
      chk("drain_lsb", exp_lsb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
